// File: rtl/sram_mem_controller.sv
// Multi-cycle MEM-stage data memory controller: each 32-bit access becomes two
// 16-bit transactions on an external asynchronous SRAM, with ready low while busy.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WW = SRAM_AW - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [WW-1:0]   word_r;
    logic [15:0]     hi_data_r;
    logic            wr_r;
    logic            req_s;
    logic [WW-1:0]   word_s;

    // Request decode, SRAM word index and the combinational pipeline hold.
    always_comb begin
        req_s  = rd_en | wr_en;
        word_s = WW'((address - 32'(ADDR_BASE)) >> 2);
        if (state_r == DONE) begin
            ready = 1'b1;
        end else if (state_r == IDLE) begin
            ready = ~req_s;
        end else begin
            ready = 1'b0;
        end
    end

    // Sequencer; pad controls are registered and set up one edge ahead of each phase cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            word_r      <= '0;
            hi_data_r   <= 16'h0000;
            wr_r        <= 1'b0;
            read_data   <= 32'h0000_0000;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= 16'h0000;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_CE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        state_r     <= LOW;
                        cnt_r       <= '0;
                        word_r      <= word_s;
                        hi_data_r   <= write_data[31:16];
                        wr_r        <= wr_en;
                        SRAM_ADDR   <= {word_s, 1'b0};
                        SRAM_DQ_out <= write_data[15:0];
                        SRAM_DQ_oe  <= wr_en;
                        SRAM_WE_N   <= ~wr_en;
                        SRAM_OE_N   <= wr_en;
                        SRAM_CE_N   <= 1'b0;
                        SRAM_UB_N   <= 1'b0;
                        SRAM_LB_N   <= 1'b0;
                    end
                end
                LOW, HIGH: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_r     <= cnt_r + CW'(1);
                        // Release WE one cycle early so data is held past the strobe edge.
                        SRAM_WE_N <= ~wr_r | ((cnt_r + CW'(1)) == CNT_LAST);
                    end else begin
                        cnt_r <= '0;
                        if (state_r == LOW) begin
                            state_r     <= HIGH;
                            SRAM_ADDR   <= {word_r, 1'b1};
                            SRAM_DQ_out <= hi_data_r;
                            SRAM_WE_N   <= ~wr_r;
                            if (!wr_r) begin
                                read_data[15:0] <= SRAM_DQ_in;
                            end
                        end else begin
                            state_r    <= DONE;
                            SRAM_DQ_oe <= 1'b0;
                            SRAM_WE_N  <= 1'b1;
                            SRAM_OE_N  <= 1'b1;
                            SRAM_CE_N  <= 1'b1;
                            SRAM_UB_N  <= 1'b1;
                            SRAM_LB_N  <= 1'b1;
                            if (!wr_r) begin
                                read_data[31:16] <= SRAM_DQ_in;
                            end
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboarded bench: directed accesses push expected results; a negedge monitor
// checks busy length, write-strobe count and load data as each access completes.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] rdata0;
    logic        ready0, dq_oe0, we_n0, oe_n0, ce_n0, ub_n0, lb_n0;
    logic [17:0] addr0;
    logic [15:0] dqo0, dqi0;

    logic        wr1, rd1;
    logic [31:0] a1, d1;
    logic [31:0] rdata1;
    logic        ready1, dq_oe1, we_n1, oe_n1, ce_n1, ub_n1, lb_n1;
    logic [17:0] addr1;
    logic [15:0] dqo1, dqi1;

    logic [15:0] mem0 [0:63];
    logic [15:0] mem1 [0:63];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          busy;
        int          we;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    sram_mem_controller #(.WAIT_CYCLES(5), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(rdata0), .ready(ready0), .SRAM_ADDR(addr0),
        .SRAM_DQ_out(dqo0), .SRAM_DQ_in(dqi0), .SRAM_DQ_oe(dq_oe0), .SRAM_WE_N(we_n0),
        .SRAM_OE_N(oe_n0), .SRAM_CE_N(ce_n0), .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0)
    );

    sram_mem_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr1), .rd_en(rd1), .address(a1),
        .write_data(d1), .read_data(rdata1), .ready(ready1), .SRAM_ADDR(addr1),
        .SRAM_DQ_out(dqo1), .SRAM_DQ_in(dqi1), .SRAM_DQ_oe(dq_oe1), .SRAM_WE_N(we_n1),
        .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
    );

    // SRAM models: write captured while WE is low, read driven while OE is low.
    assign dqi0 = (!ce_n0 && !oe_n0) ? mem0[addr0[5:0]] : 16'h0000;
    assign dqi1 = (!ce_n1 && !oe_n1) ? mem1[addr1[5:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!ce_n0 && !we_n0 && dq_oe0) mem0[addr0[5:0]] <= dqo0;
        if (!ce_n1 && !we_n1 && dq_oe1) mem1[addr1[5:0]] <= dqo1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles and WE-low cycles, compare when ready returns.
    int busy = 0;
    int wecnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy  = 0;
            wecnt = 0;
        end else if (!ready0) begin
            busy++;
            if (!we_n0) wecnt++;
        end else if (busy != 0) begin
            if (q.size() == 0) begin
                chk("unexpected_completion", 32'(busy), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("busy_cycles", 32'(busy), 32'(e.busy));
                chk("we_low_cycles", 32'(wecnt), 32'(e.we));
                if (e.is_rd) chk("read_data", rdata0, e.data);
            end
            busy  = 0;
            wecnt = 0;
        end
    end

    task automatic access0(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
        exp_t e;
        bit   seen;
        e.is_rd = !wr;
        e.data  = exp_rd;
        e.busy  = 11;
        e.we    = wr ? 8 : 0;
        q.push_back(e);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        @(posedge clk); #1;
        chk("access_starts", {31'd0, ce_n0}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        wr1 = 1'b0; rd1 = 1'b0; a1 = 32'd0; d1 = 32'd0;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {27'd0, we_n0, oe_n0, ce_n0, ub_n0, lb_n0}, 32'h1f);
        chk("rst_dq_oe", {31'd0, dq_oe0}, 32'd0);
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        chk("rst_read_data", rdata0, 32'd0);
        chk("rst_addr", {14'd0, addr0}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 2: write 0xDEADBEEF at 1024
        access0(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0);
        wr_en = 1'b0;
        chk("mem_word0", {16'd0, mem0[0]}, 32'h0000BEEF);
        chk("mem_word1", {16'd0, mem0[1]}, 32'h0000DEAD);

        // 3: read it back
        access0(1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF);
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 4: back-to-back write then read at 1028
        access0(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'd0);
        chk("write_keeps_read_data", rdata0, 32'hDEADBEEF);
        access0(1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678);
        rd_en = 1'b0;
        chk("mem_word2", {16'd0, mem0[2]}, 32'h00005678);
        chk("mem_word3", {16'd0, mem0[3]}, 32'h00001234);

        // 5: reset during the HIGH phase of a write
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hA5A5_5A5A;
        repeat (8) @(posedge clk);
        #1;
        chk("high_phase_addr", {14'd0, addr0}, 32'd5);
        chk("high_phase_we", {31'd0, we_n0}, 32'd0);
        reset = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobes", {27'd0, we_n0, oe_n0, ce_n0, ub_n0, lb_n0}, 32'h1f);
        chk("abort_dq_oe", {31'd0, dq_oe0}, 32'd0);
        chk("abort_ready", {31'd0, ready0}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // 6: WAIT_CYCLES=1, both requests asserted -> write wins
        wr1 = 1'b1; rd1 = 1'b1; a1 = 32'd1040; d1 = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("wc1_ready", {31'd0, ready1}, (c == 3) ? 32'd1 : 32'd0);
            if (c == 1 || c == 2) chk("wc1_we_low", {31'd0, we_n1}, 32'd0);
        end
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0;
        chk("wc1_mem_lo", {16'd0, mem1[8]}, 32'h0000F00D);
        chk("wc1_mem_hi", {16'd0, mem1[9]}, 32'h0000CAFE);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
